// File: rtl/systolic_fifo_seq.sv
// Sequencer for a bank of DIM shift fifos: host fill, skewed shift-out, drain window.
// Optional busy-cycle counter on perf_cycles_o when SEQ_PERF_CNT_EN is defined.
module systolic_fifo_seq #(
  parameter int DIM   = 8,
  parameter int DEPTH = 8,
  parameter int DRAIN = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             load_valid_i,
  output logic             load_ready_o,
  input  logic             stall_i,
  output logic [DIM-1:0]   fifo_en_o,
  output logic             fill_sel_o,
  output logic             array_en_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [15:0]      perf_cycles_o
);

  // state | meaning
  // IDLE  | waiting for start, all outputs low
  // FILL  | one fifo shift per accepted host beat, DEPTH beats
  // RUN   | skewed shift-out, DEPTH+DIM-1 unstalled cycles
  // DRAIN | array enabled only, DRAIN unstalled cycles
  // DONE  | single-cycle completion pulse
  typedef enum logic [2:0] {IDLE, FILL, RUN, DRAIN_ST, DONE} state_t;

  localparam int CW = $clog2(DEPTH + DIM + DRAIN + 1);
  localparam logic [CW-1:0] FILL_LAST  = CW'(DEPTH - 1);
  localparam logic [CW-1:0] RUN_LAST   = CW'(DEPTH + DIM - 2);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    load_ready_o = 1'b0;
    fifo_en_o    = '0;
    fill_sel_o   = 1'b0;
    array_en_o   = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = FILL;
          cnt_d   = '0;
        end
      end
      FILL: begin
        busy_o       = 1'b1;
        load_ready_o = 1'b1;
        fill_sel_o   = 1'b1;
        fifo_en_o    = {DIM{load_valid_i}};
        if (load_valid_i) begin
          if (cnt_q == FILL_LAST) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      RUN: begin
        busy_o     = 1'b1;
        array_en_o = !stall_i;
        if (!stall_i) begin
          // row i is live for DEPTH cycles starting i cycles after row 0
          for (int i = 0; i < DIM; i++)
            fifo_en_o[i] = (int'(cnt_q) >= i) && (int'(cnt_q) < i + DEPTH);
          if (cnt_q == RUN_LAST) begin
            state_d = DRAIN_ST;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      DRAIN_ST: begin
        busy_o     = 1'b1;
        array_en_o = !stall_i;
        if (!stall_i) begin
          if (cnt_q == DRAIN_LAST) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      DONE: begin
        busy_o  = 1'b1;
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef SEQ_PERF_CNT_EN
  logic [15:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (state_q == IDLE && start_i)
      perf_d = '0;
    else if (busy_o && perf_q != 16'hFFFF)
      perf_d = perf_q + 16'd1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) perf_q <= '0;
    else          perf_q <= perf_d;
  end

  assign perf_cycles_o = perf_q;
`else
  assign perf_cycles_o = 16'h0;
`endif

endmodule

// File: tb/tb_systolic_fifo_seq.sv
// Directed bench for systolic_fifo_seq (DIM=4, DEPTH=4, DRAIN=3).
module tb_systolic_fifo_seq;
  localparam int DIM = 4, DEPTH = 4, DRAIN = 3;

`ifdef SEQ_PERF_CNT_EN
  localparam logic [15:0] PERF_NOM   = 16'd14;
  localparam logic [15:0] PERF_STALL = 16'd17;
`else
  localparam logic [15:0] PERF_NOM   = 16'd0;
  localparam logic [15:0] PERF_STALL = 16'd0;
`endif

  logic clk, rst_n, start, lv, stall;
  logic load_ready, fill_sel, array_en, busy, done;
  logic [DIM-1:0] fifo_en;
  logic [15:0] perf;

  int checks = 0, errors = 0, cyc = 0, nd = 0;
  logic [3:0] run_exp [0:6];
  logic       gap_pat [0:6];

  systolic_fifo_seq #(.DIM(DIM), .DEPTH(DEPTH), .DRAIN(DRAIN)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .load_valid_i(lv),
    .load_ready_o(load_ready), .stall_i(stall), .fifo_en_o(fifo_en),
    .fill_sel_o(fill_sel), .array_en_o(array_en), .busy_o(busy),
    .done_o(done), .perf_cycles_o(perf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    run_exp = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
    gap_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    rst_n = 1'b0; start = 1'b0; lv = 1'b0; stall = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_fifo_en", 32'(fifo_en), 0);
    chk("rst_ready", 32'(load_ready), 0);
    chk("rst_array_en", 32'(array_en), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_perf", 32'(perf), 0);
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    step();

    // IDLE ignores load_valid
    lv = 1'b1; #1;
    chk("idle_ready", 32'(load_ready), 0);
    chk("idle_fifo_en", 32'(fifo_en), 0);
    step();
    chk("idle_busy", 32'(busy), 0);

    // nominal run with start pulses while busy
    start = 1'b1; #1;
    chk("start_idle_busy", 32'(busy), 0);
    cyc = 0; step();
    for (int k = 0; k < 4; k++) begin
      start = (k == 1); #1;
      chk("fill_en", 32'(fifo_en), 32'hF);
      chk("fill_ready", 32'(load_ready), 1);
      chk("fill_sel", 32'(fill_sel), 1);
      chk("fill_array_en", 32'(array_en), 0);
      step();
    end
    for (int k = 0; k < 7; k++) begin
      start = (k == 3); #1;
      chk("run_en", 32'(fifo_en), 32'(run_exp[k]));
      chk("run_array_en", 32'(array_en), 1);
      chk("run_sel", 32'(fill_sel), 0);
      chk("run_ready", 32'(load_ready), 0);
      step();
    end
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("drain_en", 32'(fifo_en), 0);
      chk("drain_array_en", 32'(array_en), 1);
      chk("drain_done", 32'(done), 0);
      step();
    end
    start = 1'b1; #1;
    chk("nom_done", 32'(done), 1);
    chk("nom_done_busy", 32'(busy), 1);
    chk("nom_latency", 32'(cyc), 15);
    chk("nom_perf", 32'(perf), 32'(PERF_NOM));
    step();
    start = 1'b0; #1;
    chk("post_done", 32'(done), 0);
    chk("post_busy", 32'(busy), 0);
    nd = 0;
    repeat (20) begin
      step();
      if (done) nd++;
    end
    chk("no_extra_done", 32'(nd), 0);

    // fill with load_valid gaps
    start = 1'b1; #1;
    cyc = 0; step();
    start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      lv = gap_pat[k]; #1;
      chk("gap_en", 32'(fifo_en), 32'({DIM{gap_pat[k]}}));
      chk("gap_sel", 32'(fill_sel), 1);
      step();
    end
    #1;
    chk("gap_run_sel", 32'(fill_sel), 0);
    chk("gap_run_en", 32'(fifo_en), 32'h1);
    while (!done && cyc < 60) step();
    chk("gap_latency", 32'(cyc), 18);
    step();

    // 3-cycle stall at RUN cnt=2
    lv = 1'b1; start = 1'b1; #1;
    cyc = 0; step();
    start = 1'b0;
    repeat (6) step();
    #1;
    chk("pre_stall_en", 32'(fifo_en), 32'h7);
    for (int k = 0; k < 3; k++) begin
      stall = 1'b1; #1;
      chk("stall_en", 32'(fifo_en), 0);
      chk("stall_array_en", 32'(array_en), 0);
      chk("stall_busy", 32'(busy), 1);
      step();
    end
    stall = 1'b0; #1;
    chk("post_stall_en", 32'(fifo_en), 32'h7);
    chk("post_stall_array_en", 32'(array_en), 1);
    while (!done && cyc < 60) step();
    chk("stall_latency", 32'(cyc), 18);
    chk("stall_perf", 32'(perf), 32'(PERF_STALL));
    step();

    // reset mid-RUN
    start = 1'b1; #1;
    cyc = 0; step();
    start = 1'b0;
    repeat (6) step();
    #1;
    chk("mid_run_en", 32'(fifo_en), 32'h7);
    rst_n = 1'b0; #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_en", 32'(fifo_en), 0);
    chk("mid_rst_array_en", 32'(array_en), 0);
    chk("mid_rst_ready", 32'(load_ready), 0);
    step();
    rst_n = 1'b1;
    step();
    chk("rel_busy", 32'(busy), 0);
    chk("rel_done", 32'(done), 0);
    chk("rel_perf", 32'(perf), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/systolic_fifo_seq.md
Name: systolic_fifo_seq

Overview:
- Controller sequencing a bank of DIM delay fifos (each DEPTH x BITS, shift-on-enable) that feed one edge of the systolic array.
- Three jobs per operation:
  - Parallel fill of all fifos from a host beat stream.
  - Skewed shift-out: fifo row i starts i cycles after row 0.
  - Drain window so array results can propagate.
- Sits between the host load interface and the fifo bank / array enables.
- Generates only enables and selects; the BITS-wide data path stays outside this block.

Parameters:
- DIM, 8: number of fifos (array rows); legal range 2..32.
- DEPTH, 8: entries per fifo; must equal the fifo bank's DEPTH; legal range 2..64.
- DRAIN, 8: array_en cycles after the last shift, used for result propagation; 1..255.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin an operation.
- load_valid  in  1  host beat present; one beat carries one word for every row.
- load_ready  out  1  beat accepted this cycle when load_valid=1.
- stall  in  1  array back-pressure; freezes RUN/DRAIN.
- fifo_en  out  DIM  per-fifo shift enable.
- fill_sel  out  1  1 = fifo d from host data; 0 = fifo d forced to zero.
- array_en  out  1  systolic array compute enable.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when the operation completes.
- perf_cycles  out  16  busy-cycle count (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0): state=IDLE, all counters 0. Outputs: load_ready=0, fifo_en=0, fill_sel=0, array_en=0, busy=0, done=0, perf_cycles=0.
- State register and all flops update on posedge clk only, except the async reset.
- Counter width is $clog2(DEPTH+DIM+DRAIN+1).
- IDLE:
  - All outputs 0.
  - start=1 -> FILL with cnt=0.
  - load_valid is ignored.
- FILL:
  - load_ready=1 and fill_sel=1.
  - fifo_en = {DIM{load_valid}}, so every fifo shifts exactly when a beat is accepted.
  - cnt increments per accepted beat.
  - On the accept that makes cnt=DEPTH -> RUN with cnt=0.
  - Gaps in load_valid simply hold the state.
  - stall has no effect in FILL.
- RUN:
  - fill_sel=0, load_ready=0, array_en=!stall.
  - fifo_en[i] = !stall && (cnt >= i) && (cnt < i+DEPTH). This gives a triangular skew, with zeros shifted in behind the data.
  - cnt increments when !stall.
  - After cycle DEPTH+DIM-2 has executed unstalled -> DRAIN with cnt=0.
  - Total unstalled RUN cycles = DEPTH+DIM-1.
- DRAIN:
  - fifo_en=0, array_en=!stall.
  - cnt increments when !stall.
  - After DRAIN unstalled cycles -> DONE.
- DONE:
  - done=1 and busy=1 for exactly one cycle, then -> IDLE.
  - A start in the DONE cycle is ignored.
- start while busy: ignored, with no queueing.
- stall: freezes cnt and drives fifo_en and array_en low combinationally in the same cycle; the state holds.
- All outputs are combinational decodes of state, cnt and the stall/load_valid inputs. There is no extra register stage, so fifo_en takes effect at the same clock edge.
- Reset mid-operation returns immediately to IDLE with all outputs 0. Fifo contents are the fifo bank's own concern.
- Minimum latency from start to done with no stall and continuous load_valid: 1 + DEPTH + (DEPTH+DIM-1) + DRAIN cycles, with start sampled in IDLE.

Optional Feature:
- Macro: SEQ_PERF_CNT_EN.
- Defined:
  - perf_cycles counts clocks with busy=1, including stalled cycles.
  - It clears on the start acceptance cycle and saturates at 16'hFFFF.
  - It holds its value in IDLE until the next start.
  - It clears on reset.
- Undefined: perf_cycles is tied to 16'h0 and no counter flops are inferred.

Test Plan:
- Reset: assert rst_n=0 mid-RUN with DIM=8, DEPTH=8 -> same-cycle busy=0, fifo_en=0, array_en=0; after release, state=IDLE and done=0.
- Nominal (DIM=4, DEPTH=4, DRAIN=3), continuous load_valid, no stall:
  - fifo_en=4'hF for 4 FILL cycles.
  - RUN fifo_en sequence over 7 cycles: 1,3,7,F,E,C,8.
  - array_en high for 7+3 cycles.
  - done pulses 1+4+7+3=15 cycles after start.
- Fill gaps: load_valid pattern 1,0,0,1,1,0,1 -> exactly 4 fifo_en pulses, each aligned to load_valid=1; RUN entered after the 4th beat.
- Stall: stall=1 for 3 cycles at RUN cnt=2 -> fifo_en=0 and array_en=0 during the stall, cnt holds at 2, and done is delayed by exactly 3 cycles.
- Start while busy: start pulses during FILL, RUN and DONE -> no restart; exactly one done per accepted start.
- SEQ_PERF_CNT_EN defined, nominal run as above with one 3-cycle stall -> perf_cycles=17 after done; with the macro undefined, perf_cycles=0 throughout.
